// File: rtl/mult_div_unit_if.sv
// rtl/mult_div_unit_if.sv - request/result signal bundle for mult_div_unit
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] oper_a;
    logic [WIDTH-1:0] oper_b;
    logic             hi_write;
    logic             lo_write;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (
        output start, op, oper_a, oper_b, hi_write, lo_write,
        input  busy, done, div_by_zero, HI, LO
    );

    modport slave (
        input  start, op, oper_a, oper_b, hi_write, lo_write,
        output busy, done, div_by_zero, HI, LO
    );
endinterface

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - multicycle MULT/MULTU/DIV/DIVU unit with HI/LO registers
// Divider datapath is built only when MULT_DIV_DIVIDE_EN is defined.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic            Clk,
    input  logic            reset,
    mult_div_unit_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic             prod_neg;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic             busy_r;
    logic             done_r;
    logic             dbz_r;
`ifdef MULT_DIV_DIVIDE_EN
    logic             div_r;
    logic             rem_neg;
`endif

    // Only the signed ops (op[0]=0) strip signs; the unsigned core fixes them up in FIX.
    logic             op_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    assign op_signed = ~bus.op[0];
    assign a_neg     = op_signed & bus.oper_a[WIDTH-1];
    assign b_neg     = op_signed & bus.oper_b[WIDTH-1];
    assign mag_a     = a_neg ? (-bus.oper_a) : bus.oper_a;
    assign mag_b     = b_neg ? (-bus.oper_b) : bus.oper_b;

    // Shift-add step: multiplier sits in acc_lo and drains out of its LSB.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod_fix;
    assign mul_sum  = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? mcand : {WIDTH{1'b0}})};
    assign prod_fix = prod_neg ? (-{acc_hi, acc_lo}) : {acc_hi, acc_lo};

`ifdef MULT_DIV_DIVIDE_EN
    // Restoring step: acc_hi is the partial remainder, acc_lo the dividend/quotient.
    logic [WIDTH:0]   div_trial;
    logic [WIDTH-1:0] quot_fix;
    logic [WIDTH-1:0] rem_fix;
    assign div_trial = {acc_hi, acc_lo[WIDTH-1]} - {1'b0, mcand};
    assign quot_fix  = prod_neg ? (-acc_lo) : acc_lo;
    assign rem_fix   = rem_neg  ? (-acc_hi) : acc_hi;
`endif

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            mcand    <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            prod_neg <= 1'b0;
            hi_r     <= '0;
            lo_r     <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            dbz_r    <= 1'b0;
`ifdef MULT_DIV_DIVIDE_EN
            div_r    <= 1'b0;
            rem_neg  <= 1'b0;
`endif
        end else begin
            if (!busy_r) begin
                if (bus.hi_write) hi_r <= bus.oper_a;
                if (bus.lo_write) lo_r <= bus.oper_a;
            end
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        mcand    <= mag_b;
                        acc_hi   <= '0;
                        acc_lo   <= mag_a;
                        prod_neg <= a_neg ^ b_neg;
                        cnt      <= CW'(WIDTH - 1);
                        dbz_r    <= 1'b0;
`ifdef MULT_DIV_DIVIDE_EN
                        div_r    <= bus.op[1];
                        rem_neg  <= a_neg;
                        if (bus.op[1] && (bus.oper_b == '0)) begin
                            state  <= DONE;
                            done_r <= 1'b1;
                            dbz_r  <= 1'b1;
                        end else begin
                            state  <= CALC;
                            busy_r <= 1'b1;
                        end
`else
                        if (bus.op[1]) begin
                            state  <= DONE;
                            done_r <= 1'b1;
                        end else begin
                            state  <= CALC;
                            busy_r <= 1'b1;
                        end
`endif
                    end
                end
                CALC: begin
`ifdef MULT_DIV_DIVIDE_EN
                    if (div_r) begin
                        if (!div_trial[WIDTH]) begin
                            acc_hi <= div_trial[WIDTH-1:0];
                            acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_hi <= {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
                            acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
                    end
`else
                    {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
`endif
                    if (cnt == '0) state <= FIX;
                    else           cnt   <= cnt - 1'b1;
                end
                FIX: begin
`ifdef MULT_DIV_DIVIDE_EN
                    if (div_r) begin
                        hi_r <= rem_fix;
                        lo_r <= quot_fix;
                    end else begin
                        {hi_r, lo_r} <= prod_fix;
                    end
`else
                    {hi_r, lo_r} <= prod_fix;
`endif
                    state  <= DONE;
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.div_by_zero = dbz_r;
    assign bus.HI          = hi_r;
    assign bus.LO          = lo_r;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - directed self-checking bench for mult_div_unit
module tb_mult_div_unit;
    logic Clk;
    logic reset;
    int   checks;
    int   failures;
    int   lat;
    int   bcnt;
    int   dcnt;

    mult_div_unit_if #(.WIDTH(32)) bus ();

    mult_div_unit #(.WIDTH(32)) dut (
        .Clk   (Clk),
        .reset (reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Leaves the bench at the falling edge just after the accepting edge E0.
    task automatic pulse_start(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge Clk);
        bus.start = 1'b1; bus.op = o; bus.oper_a = a; bus.oper_b = b;
        @(posedge Clk);
        @(negedge Clk);
        bus.start = 1'b0;
    endtask

    // lat = number of rising edges from E0 (inclusive) until done is seen high.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, output int l, output int bc);
        pulse_start(o, a, b);
        l  = 1;
        bc = 0;
        while (!bus.done && l < 100) begin
            if (bus.busy) bc++;
            @(negedge Clk);
            l++;
        end
        @(negedge Clk);
        chk({tag, "_done_single"}, {62'd0, bus.done, bus.busy}, 64'd0);
    endtask

    task automatic mtx(input logic hw, input logic lw, input logic [31:0] d);
        @(negedge Clk);
        bus.hi_write = hw; bus.lo_write = lw; bus.oper_a = d;
        @(negedge Clk);
        bus.hi_write = 1'b0; bus.lo_write = 1'b0;
    endtask

    initial begin
        checks = 0; failures = 0;
        reset = 1'b0;
        bus.start = 1'b0; bus.op = 2'b00; bus.oper_a = '0; bus.oper_b = '0;
        bus.hi_write = 1'b0; bus.lo_write = 1'b0;
        repeat (2) @(negedge Clk);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_dbz",  64'(bus.div_by_zero), 64'd0);
        chk("rst_hi",   64'(bus.HI), 64'd0);
        chk("rst_lo",   64'(bus.LO), 64'd0);
        reset = 1'b1;

        run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7, lat, bcnt);
        chk("mult_neg_lat",  64'(lat), 64'd34);
        chk("mult_neg_busy", 64'(bcnt), 64'd33);
        chk("mult_neg_hi",   64'(bus.HI), 64'hFFFF_FFFF);
        chk("mult_neg_lo",   64'(bus.LO), 64'hFFFF_FFEB);

        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcnt);
        chk("multu_max_hi", 64'(bus.HI), 64'hFFFF_FFFE);
        chk("multu_max_lo", 64'(bus.LO), 64'h0000_0001);

        run_op("mult_m1", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcnt);
        chk("mult_m1_hi", 64'(bus.HI), 64'd0);
        chk("mult_m1_lo", 64'(bus.LO), 64'd1);

`ifdef MULT_DIV_DIVIDE_EN
        run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, lat, bcnt);
        chk("div_neg_lat", 64'(lat), 64'd34);
        chk("div_neg_lo",  64'(bus.LO), 64'hFFFF_FFFD);
        chk("div_neg_hi",  64'(bus.HI), 64'hFFFF_FFFF);
        run_op("divu", 2'b11, 32'd100, 32'd7, lat, bcnt);
        chk("divu_lo", 64'(bus.LO), 64'd14);
        chk("divu_hi", 64'(bus.HI), 64'd2);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt);
        chk("div_ovf_lo", 64'(bus.LO), 64'h8000_0000);
        chk("div_ovf_hi", 64'(bus.HI), 64'd0);
`else
        run_op("divu_off", 2'b11, 32'd100, 32'd7, lat, bcnt);
        chk("divu_off_lat", 64'(lat), 64'd1);
        chk("divu_off_lo",  64'(bus.LO), 64'd1);
        chk("divu_off_hi",  64'(bus.HI), 64'd0);
        chk("divu_off_dbz", 64'(bus.div_by_zero), 64'd0);
`endif

        mtx(1'b1, 1'b0, 32'h1234);
        chk("mthi", 64'(bus.HI), 64'h1234);
        mtx(1'b0, 1'b1, 32'h5678);
        chk("mtlo", 64'(bus.LO), 64'h5678);

        run_op("divz", 2'b11, 32'd5, 32'd0, lat, bcnt);
        chk("divz_lat", 64'(lat), 64'd1);
`ifdef MULT_DIV_DIVIDE_EN
        chk("divz_flag", 64'(bus.div_by_zero), 64'd1);
`else
        chk("divz_flag", 64'(bus.div_by_zero), 64'd0);
`endif
        chk("divz_hi", 64'(bus.HI), 64'h1234);
        chk("divz_lo", 64'(bus.LO), 64'h5678);

        run_op("multu_small", 2'b01, 32'd2, 32'd3, lat, bcnt);
        chk("multu_small_dbz", 64'(bus.div_by_zero), 64'd0);
        chk("multu_small_lo",  64'(bus.LO), 64'd6);
        chk("multu_small_hi",  64'(bus.HI), 64'd0);

        // Mid-CALC restart and MTHI must both be dropped.
        pulse_start(2'b01, 32'd3, 32'd4);
        dcnt = 0;
        repeat (4) @(negedge Clk);
        bus.start = 1'b1; bus.op = 2'b00; bus.oper_a = 32'd5; bus.oper_b = 32'd5;
        @(negedge Clk);
        bus.start = 1'b0;
        repeat (2) @(negedge Clk);
        bus.hi_write = 1'b1; bus.oper_a = 32'hDEAD;
        @(negedge Clk);
        bus.hi_write = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (bus.done) dcnt++;
            @(negedge Clk);
        end
        chk("ignore_done_cnt", 64'(dcnt), 64'd1);
        chk("ignore_hi", 64'(bus.HI), 64'd0);
        chk("ignore_lo", 64'(bus.LO), 64'd12);

        pulse_start(2'b00, 32'h1234, 32'h10);
        repeat (9) @(negedge Clk);
        #1 reset = 1'b0;
        #1;
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_done", 64'(bus.done), 64'd0);
        chk("abort_hi",   64'(bus.HI), 64'd0);
        chk("abort_lo",   64'(bus.LO), 64'd0);
        @(negedge Clk);
        reset = 1'b1;

        run_op("mult_after", 2'b00, 32'd6, 32'd7, lat, bcnt);
        chk("mult_after_lat", 64'(lat), 64'd34);
        chk("mult_after_lo",  64'(bus.LO), 64'd42);
        chk("mult_after_hi",  64'(bus.HI), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
